// File: rtl/grant_decoder.sv
// grant_decoder: registered binary-to-one-hot grant decoder with break-before-make.
// Accepts a port index over valid/ready and drives a one-hot grant to that port.
// The grant is held until the granted port releases it, then one all-zero GAP
// cycle follows before a new index is accepted.
// Optional feature macro: GRANT_TIMEOUT_EN. When it is defined, a 16-bit hold
// counter revokes the grant after TIMEOUT_CYCLES cycles and pulses `timeout`.
// When it is undefined, a grant is held until release and `timeout` is tied to 0.
module grant_decoder #(
    parameter int          INPUT_WIDTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int         N              = 2 ** INPUT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [INPUT_WIDTH-1:0] encoded_input,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:N-1]           release_in,
    output logic [0:N-1]           decoded_output,
    output logic                   grant_valid,
    output logic [INPUT_WIDTH-1:0] granted_index,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t state;

    logic accept;
    logic release_hit;
    logic timeout_hit;

    // Bit 0 is the leftmost bit of the grant vector, so the index addresses the
    // ascending range directly.
    function automatic logic [0:N-1] to_onehot(input logic [INPUT_WIDTH-1:0] idx);
        logic [0:N-1] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // in_ready is only ever high in IDLE, so this is the IDLE -> GRANT condition.
    assign accept      = in_valid & in_ready;
    // Only the currently granted port's release bit matters.
    assign release_hit = release_in[granted_index];

`ifdef GRANT_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] hold_cnt;
    logic        timeout_r;

    // Hold counter saturates instead of wrapping; the exit fires at TIMEOUT_LIM
    // so the saturated value is never relied upon.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign timeout_hit = (state == S_GRANT) && (hold_cnt == TIMEOUT_LIM);
    assign timeout     = timeout_r;

    // Hold counter: 1 on the first grant cycle, +1 on each further grant cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt <= 16'd0;
        end else if (state == S_IDLE && accept) begin
            hold_cnt <= 16'd1;
        end else if (state == S_GRANT) begin
            hold_cnt <= sat_inc(hold_cnt);
        end
    end
`else
    logic unused_timeout_cfg;

    // Without the counter the timeout parameter carries no meaning.
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout            = 1'b0;
`endif

    // Grant FSM: IDLE accepts an index, GRANT holds it, GAP forces one empty cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            in_ready       <= 1'b0;
            decoded_output <= '0;
            grant_valid    <= 1'b0;
            granted_index  <= '0;
`ifdef GRANT_TIMEOUT_EN
            timeout_r      <= 1'b0;
`endif
        end else begin
`ifdef GRANT_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        state          <= S_GRANT;
                        in_ready       <= 1'b0;
                        decoded_output <= to_onehot(encoded_input);
                        grant_valid    <= 1'b1;
                        granted_index  <= encoded_input;
                    end
                end
                S_GRANT: begin
                    // Release takes priority over a simultaneous timeout.
                    if (release_hit) begin
                        state          <= S_GAP;
                        decoded_output <= '0;
                        grant_valid    <= 1'b0;
                    end else if (timeout_hit) begin
                        state          <= S_GAP;
                        decoded_output <= '0;
                        grant_valid    <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
                        timeout_r      <= 1'b1;
`endif
                    end
                end
                S_GAP: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state          <= S_IDLE;
                    in_ready       <= 1'b0;
                    decoded_output <= '0;
                    grant_valid    <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_never_multihot: assert property (@(posedge clk) disable iff (!reset_n)
        $countones(decoded_output) <= 1);
    a_valid_matches_grant: assert property (@(posedge clk) disable iff (!reset_n)
        grant_valid == (|decoded_output));
    a_ready_only_idle: assert property (@(posedge clk) disable iff (!reset_n)
        in_ready |-> (state == S_IDLE));
`endif

endmodule

// File: tb/tb_grant_decoder.sv
// Bench for grant_decoder: directed requests, expectations queued at issue time,
// a negedge monitor pops and compares whenever a grant appears or drops.
`timescale 1ns/1ps
module tb_grant_decoder;

    localparam int IW = 8;
    localparam int N  = 256;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [IW-1:0] encoded_input = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [0:N-1]  release_in = '0;
    logic [0:N-1]  decoded_output;
    logic          grant_valid;
    logic [IW-1:0] granted_index;
    logic          timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [IW-1:0] idx;
        int            acc_cyc;
        int            exp_len;
        bit            exp_to;
    } exp_t;

    exp_t sb[$];

    grant_decoder #(
        .INPUT_WIDTH    (IW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .encoded_input  (encoded_input),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .release_in     (release_in),
        .decoded_output (decoded_output),
        .grant_valid    (grant_valid),
        .granted_index  (granted_index),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_i(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_w(input string name, input logic [0:N-1] act, input logic [0:N-1] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected one-hot: a single 1 at the leftmost position shifted right by idx.
    function automatic logic [0:N-1] exp_vec(input logic [IW-1:0] i);
        logic [0:N-1] v;
        v    = '0;
        v[0] = 1'b1;
        return v >> i;
    endfunction

    // Monitor
    logic prev_gv = 1'b0;
    bit   have_cur = 1'b0;
    bit   chk_next = 1'b0;
    int   rise_cyc = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (reset_n === 1'b1 || cyc > 0) begin
            check_i("never_multihot", 32'($countones(decoded_output) <= 1), 32'd1);
        end
        if (chk_next) begin
            check_i("ready_after_gap", 32'(in_ready), 32'd1);
            check_i("timeout_single_pulse", 32'(timeout), 32'd0);
            chk_next = 1'b0;
        end
        if (grant_valid === 1'b1 && prev_gv !== 1'b1) begin
            if (sb.size() == 0) begin
                check_i("unexpected_grant", 32'(granted_index), 32'hFFFF_FFFF);
            end else begin
                cur      = sb.pop_front();
                have_cur = 1'b1;
                rise_cyc = cyc;
                check_i("grant_latency", 32'(cyc), 32'(cur.acc_cyc));
                check_i("granted_index", 32'(granted_index), 32'(cur.idx));
                check_w("decoded_onehot", decoded_output, exp_vec(cur.idx));
                check_i("ready_low_in_grant", 32'(in_ready), 32'd0);
            end
        end else if (grant_valid !== 1'b1 && prev_gv === 1'b1 && have_cur) begin
            check_i("grant_length", 32'(cyc - rise_cyc), 32'(cur.exp_len));
            check_i("timeout_at_drop", 32'(timeout), 32'(cur.exp_to));
            check_w("gap_all_zero", decoded_output, '0);
            check_i("ready_low_in_gap", 32'(in_ready), 32'd0);
            have_cur = 1'b0;
            chk_next = 1'b1;
        end
        prev_gv = grant_valid;
    end

    // hold > 0: release on grant cycle `hold`; hold == 0: wait for the grant to
    // drop by itself; hold < 0: return on the first grant cycle.
    task automatic issue(input logic [IW-1:0] idx, input int hold, input int wrong_port,
                         input int wrong_at, input int exp_len, input bit exp_to,
                         input bit keep_valid, output int acc);
        int   waited;
        exp_t e;
        waited        = 0;
        encoded_input = idx;
        in_valid      = 1'b1;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            check_i("accept_wait_expired", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            acc      = -1;
            return;
        end
        @(posedge clk); #1;
        acc       = cyc;
        e.idx     = idx;
        e.acc_cyc = acc;
        e.exp_len = exp_len;
        e.exp_to  = exp_to;
        sb.push_back(e);
        if (!keep_valid) in_valid = 1'b0;
        if (hold > 0) begin
            for (int g = 1; g <= hold; g++) begin
                release_in = '0;
                if (g == wrong_at) release_in[wrong_port] = 1'b1;
                if (g == hold) release_in[idx] = 1'b1;
                @(posedge clk); #1;
            end
            release_in = '0;
        end else if (hold == 0) begin
            waited = 0;
            while (grant_valid === 1'b1 && waited < 300) begin
                @(posedge clk); #1;
                waited++;
            end
            check_i("self_drop_wait", 32'(grant_valid), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_i({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_w({tag, "_decoded"}, decoded_output, '0);
        check_i({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
        check_i({tag, "_granted_index"}, 32'(granted_index), 32'd0);
        check_i({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        int a0;
        int a1;
        int r;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_i("ready_after_reset", 32'(in_ready), 32'd1);

        // Port 5; a release of port 3 on grant cycle 2 must be ignored.
        issue(8'd5, 4, 3, 2, 4, 1'b0, 1'b0, a0);

`ifdef GRANT_TIMEOUT_EN
        issue(8'd200, 0, 0, 0, TO, 1'b1, 1'b0, a0);
        issue(8'd200, TO, 0, 0, TO, 1'b0, 1'b0, a0);
`else
        issue(8'd200, 120, 0, 0, 120, 1'b0, 1'b0, a0);
`endif

        // Back-to-back with in_valid held high.
        issue(8'd0, 1, 0, 0, 1, 1'b0, 1'b1, a0);
        issue(8'd255, 1, 0, 0, 1, 1'b0, 1'b1, a1);
        in_valid = 1'b0;
        check_i("accept_spacing", 32'(a1 - a0), 32'd3);

        // Reset on the third grant cycle.
        issue(8'd77, -1, 0, 0, 3, 1'b0, 1'b0, a0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        r = cyc;
        check_reset_values("midrst");
        reset_n = 1'b1;
        issue(8'd9, 2, 0, 0, 2, 1'b0, 1'b0, a1);
        check_i("accept_after_reset", 32'(a1 - r), 32'd2);

        repeat (5) @(posedge clk);
        #1;
        check_i("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/grant_decoder.md
# grant_decoder

Registered binary-to-one-hot grant decoder: it accepts a port index over a valid/ready handshake, drives a one-hot grant to that port, and holds the grant until the port releases it or an optional timeout expires. It sits downstream of the arbiter's priority encoder and turns the winning index into per-port select lines. A mandatory one-cycle gap between grants guarantees break-before-make.

## Interface
- `INPUT_WIDTH`, default 8: index width; the block drives 2**INPUT_WIDTH grant lines (N).
- `TIMEOUT_CYCLES`, default 1024: maximum grant hold in cycles (range 1..65535); used only when the timeout feature is compiled in.

- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `encoded_input`  in  INPUT_WIDTH  requested port index.
- `in_valid`  in  1  `encoded_input` is valid.
- `in_ready`  out  1  block can accept an index.
- `release_in`  in  [0:N-1]  per-port release request; only the bit of the currently granted port is observed.
- `decoded_output`  out  [0:N-1]  one-hot grant; bit 0 is the leftmost bit, matching the encoder's input ordering.
- `grant_valid`  out  1  a grant is active (OR of `decoded_output`, registered).
- `granted_index`  out  INPUT_WIDTH  index of the active grant; holds its last value when no grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, no grant.
  - GRANT: one-hot grant driven.
  - GAP: all grants 0, `in_ready`=0, lasts exactly one cycle.
- IDLE → GRANT on `in_valid & in_ready`. The block registers `encoded_input` into `granted_index` and sets `decoded_output[encoded_input]`=1, with every other bit 0.
- GRANT → GAP when `release_in[granted_index]`=1, or (feature on) when the hold counter reaches `TIMEOUT_CYCLES`.
- GAP → IDLE unconditionally.
- `in_valid` is ignored outside IDLE. The upstream block must hold `encoded_input` stable while `in_valid & !in_ready`.
- `release_in` bits of non-granted ports are ignored. `release_in` is ignored in IDLE and GAP.
- Hold counter: 16-bit. Loads 1 on the first GRANT cycle and increments each GRANT cycle. It saturates and has no wrap-around, because the exit condition fires at `TIMEOUT_CYCLES`.
- If release and timeout occur in the same cycle, release wins: the block exits to GAP and `timeout` stays 0.
- `decoded_output` is never multi-hot. At most one bit is set in any cycle.
- Reset values: `in_ready`=0 during reset and 1 from the first cycle after `reset_n` deasserts. `decoded_output`=0, `grant_valid`=0, `granted_index`=0, `timeout`=0, FSM=IDLE, counter=0.
- Reset asserted mid-grant clears the grant at the next edge. No GAP cycle is inserted and no `timeout` pulse is produced.

## Timing
- Accept at edge k. Then `decoded_output`, `grant_valid` and `granted_index` are valid from cycle k+1, giving 1-cycle latency.
- Release sampled at edge m. Then the grant is 0 from cycle m+1 (GAP), and `in_ready`=1 from cycle m+2.
- Minimum grant length is 1 cycle, so minimum accept-to-accept spacing is 3 cycles.
- Timeout case: the grant is active for exactly `TIMEOUT_CYCLES` cycles. `timeout` pulses high in the first GAP cycle, coincident with the grant dropping.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `GRANT_TIMEOUT_EN` defined:
  - The hold counter and timeout exit are present.
  - `timeout` behaves as described above.
- `GRANT_TIMEOUT_EN` undefined:
  - The counter logic is removed.
  - A grant is held indefinitely until release.
  - `timeout` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset, then `encoded_input`=8'd5 with `in_valid`=1 → next cycle `decoded_output` has only bit 5 set, `granted_index`=5, `grant_valid`=1, `in_ready`=0.
- Grant to port 5, then pulse `release_in[5]` at edge m → grant is 0 at m+1 and `in_ready`=1 at m+2. Pulsing `release_in[3]` beforehand has no effect.
- Timeout feature on, `TIMEOUT_CYCLES`=4, grant port 200 with no release → grant is active for exactly 4 cycles, then drops with a single-cycle `timeout` pulse. With the feature off, the grant stays active for ≥100 cycles and `timeout`=0.
- Timeout on, `TIMEOUT_CYCLES`=4, assert `release_in[200]` on the 4th grant cycle → grant drops and `timeout` remains 0.
- Back-to-back requests 0 then 255 with `in_valid` held high and 1-cycle releases → grants are separated by one all-zero cycle; accept spacing is 3 cycles; `decoded_output` is never multi-hot.
- Assert `reset_n`=0 mid-grant → all outputs are at reset values at the next edge, with no `timeout` pulse. The next request is accepted on the first cycle after `reset_n` deasserts.
